// File: rtl/bits_imem_fetch.sv
// Instruction-memory fetch unit: packs 32-bit memory reads into 128-bit words
// with a byte-valid mask and delivers them over a four-phase active-low handshake.
module bits_imem_fetch #(
    parameter int ADDR_W    = 14,
    parameter int MAX_READS = 4
) (
    input  logic              clk,
    input  logic              resetB,
    input  logic              start,
    input  logic [15:0]       expectedBytes,
    input  logic              mem_req_b,
    output logic              mem_ack_b,
    output logic [127:0]      instruction_word,
    output logic [15:0]       instruction_byte_valid,
    output logic              done_reading_memory,
    output logic              imem_ceb,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_REL   = 3'd4;

    localparam logic [15:0] WORD_BYTES = 16'(MAX_READS * 4);

    logic [2:0]        state_q, state_d;
    logic [15:0]       rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic [2:0]        nreads_q, nreads_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic              cap_valid_q, cap_valid_d;
    logic [1:0]        cap_slot_q, cap_slot_d;
    logic [127:0]      asm_q, asm_d;
    logic [127:0]      word_q, word_d;
    logic [15:0]       mask_q, mask_d;

    logic [15:0]       mask_calc;
    logic [127:0]      wmask;
    logic [2:0]        nreads_calc;

    // Byte mask for the word currently being assembled, derived from bytes remaining.
    always_comb begin
        if (rem_q >= WORD_BYTES) begin
            mask_calc   = 16'hFFFF;
            nreads_calc = 3'(MAX_READS);
        end else begin
            mask_calc   = ~(16'hFFFF >> rem_q[3:0]);
            nreads_calc = 3'(({1'b0, rem_q[3:0]} + 5'd3) >> 2);
        end
        wmask = '0;
        for (int j = 0; j < 16; j++) begin
            wmask[8*j +: 8] = {8{mask_calc[j]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        done_d      = done_q;
        nreads_d    = nreads_q;
        rd_idx_d    = rd_idx_q;
        word_d      = word_q;
        mask_d      = mask_q;
        cap_valid_d = (state_q == S_FETCH);
        cap_slot_d  = rd_idx_q;
        asm_d       = asm_q;

        // Read data arrives the cycle after its request; drop it into its slot.
        if (cap_valid_q) begin
            case (cap_slot_q)
                2'd0:    asm_d[127:96] = imem_rdata;
                2'd1:    asm_d[95:64]  = imem_rdata;
                2'd2:    asm_d[63:32]  = imem_rdata;
                default: asm_d[31:0]   = imem_rdata;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (!mem_req_b) begin
                    if (done_q || rem_q == 16'd0) begin
                        word_d  = '0;
                        mask_d  = '0;
                        state_d = S_ACK;
                    end else begin
                        nreads_d = nreads_calc;
                        rd_idx_d = 2'd0;
                        asm_d    = '0;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                addr_d   = addr_q + 1'b1;
                rd_idx_d = rd_idx_q + 2'd1;
                if ({1'b0, rd_idx_q} == nreads_q - 3'd1) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                word_d  = asm_d & wmask;
                mask_d  = mask_calc;
                state_d = S_ACK;
            end
            S_ACK: begin
                rem_d = (rem_q >= WORD_BYTES) ? rem_q - WORD_BYTES : 16'd0;
                if (rem_d == 16'd0) begin
                    done_d = 1'b1;
                end
                state_d = S_REL;
            end
            S_REL: begin
                if (mem_req_b) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new stream aborts whatever is in flight, including a concurrent request.
        if (start) begin
            state_d     = S_IDLE;
            rem_d       = expectedBytes;
            addr_d      = '0;
            done_d      = (expectedBytes == 16'd0);
            cap_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetB) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            nreads_q    <= '0;
            rd_idx_q    <= '0;
            cap_valid_q <= 1'b0;
            cap_slot_q  <= '0;
            asm_q       <= '0;
            word_q      <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            nreads_q    <= nreads_d;
            rd_idx_q    <= rd_idx_d;
            cap_valid_q <= cap_valid_d;
            cap_slot_q  <= cap_slot_d;
            asm_q       <= asm_d;
            word_q      <= word_d;
            mask_q      <= mask_d;
        end
    end

    assign mem_ack_b              = (state_q != S_ACK);
    assign imem_ceb               = (state_q != S_FETCH);
    assign imem_addr              = addr_q;
    assign instruction_word       = word_q;
    assign instruction_byte_valid = mask_q;
    assign done_reading_memory    = done_q;

endmodule

// File: tb/tb_bits_imem_fetch.sv
// Directed bench for bits_imem_fetch: table of single-word streams plus
// hand-written multi-word, held-request, abort and reset sequences.
module tb_bits_imem_fetch;

    logic         clk = 1'b0;
    logic         resetB;
    logic         start;
    logic [15:0]  expectedBytes;
    logic         mem_req_b;
    logic         mem_ack_b;
    logic [127:0] instruction_word;
    logic [15:0]  instruction_byte_valid;
    logic         done_reading_memory;
    logic         imem_ceb;
    logic [13:0]  imem_addr;
    logic [31:0]  imem_rdata = '0;

    logic [31:0]  mem [0:63];
    int           n_checks = 0;
    int           n_pass   = 0;

    typedef struct {
        logic [15:0]  eb;
        int           n;
        logic [127:0] word;
        logic [15:0]  mask;
        logic         done;
    } vec_t;

    vec_t vecs [7];

    bits_imem_fetch #(.ADDR_W(14)) dut (
        .clk                    (clk),
        .resetB                 (resetB),
        .start                  (start),
        .expectedBytes          (expectedBytes),
        .mem_req_b              (mem_req_b),
        .mem_ack_b              (mem_ack_b),
        .instruction_word       (instruction_word),
        .instruction_byte_valid (instruction_byte_valid),
        .done_reading_memory    (done_reading_memory),
        .imem_ceb               (imem_ceb),
        .imem_addr              (imem_addr),
        .imem_rdata             (imem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model: data valid the cycle after imem_ceb=0.
    always @(posedge clk) begin
        if (!imem_ceb) imem_rdata <= mem[imem_addr[5:0]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_start(input logic [15:0] eb);
        @(negedge clk);
        start = 1'b1;
        expectedBytes = eb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Request one word, check reads, latency, payload, one-cycle ack and done.
    task automatic req_word(input string tag, input int base, input int n,
                            input logic [127:0] ew, input logic [15:0] em,
                            input logic ed, input int hold);
        int   cyc;
        int   reads;
        int   lat;
        logic seen;
        logic stray;
        lat = (n == 0) ? 1 : n + 2;
        @(negedge clk);
        mem_req_b = 1'b0;
        cyc = 0; reads = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (!imem_ceb) begin
                check({tag, "_addr"}, 128'(imem_addr), 128'(base + reads));
                reads++;
            end
            if (!mem_ack_b) seen = 1'b1;
        end
        check({tag, "_latency"}, 128'(cyc), 128'(lat));
        check({tag, "_reads"}, 128'(reads), 128'(n));
        check({tag, "_word"}, instruction_word, ew);
        check({tag, "_mask"}, 128'(instruction_byte_valid), 128'(em));
        @(negedge clk);
        check({tag, "_ack_one_cycle"}, 128'(mem_ack_b), 128'(1));
        check({tag, "_done"}, 128'(done_reading_memory), 128'(ed));
        stray = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!mem_ack_b || !imem_ceb) stray = 1'b1;
        end
        if (hold > 0) check({tag, "_held_quiet"}, 128'(stray), 128'(0));
        mem_req_b = 1'b1;
        @(negedge clk);
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        logic stray;
        stray = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (!mem_ack_b || !imem_ceb) stray = 1'b1;
        end
        check(tag, 128'(stray), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h5A5A0000 | 32'(i);
        mem[0] = 32'hD2FE2800;
        mem[1] = 32'h01020304;
        mem[2] = 32'hA5A5A5A5;
        mem[3] = 32'h0F1E2D3C;
        mem[4] = 32'hCAFEBABE;
        mem[5] = 32'hDEADBEEF;
        mem[6] = 32'h13579BDF;
        mem[7] = 32'h2468ACE0;

        vecs[0] = '{16'd16, 4, 128'hD2FE2800_01020304_A5A5A5A5_0F1E2D3C, 16'hFFFF, 1'b1};
        vecs[1] = '{16'd1,  1, 128'hD2000000_00000000_00000000_00000000, 16'h8000, 1'b1};
        vecs[2] = '{16'd4,  1, 128'hD2FE2800_00000000_00000000_00000000, 16'hF000, 1'b1};
        vecs[3] = '{16'd5,  2, 128'hD2FE2800_01000000_00000000_00000000, 16'hF800, 1'b1};
        vecs[4] = '{16'd10, 3, 128'hD2FE2800_01020304_A5A50000_00000000, 16'hFFC0, 1'b1};
        vecs[5] = '{16'd15, 4, 128'hD2FE2800_01020304_A5A5A5A5_0F1E2D00, 16'hFFFE, 1'b1};
        vecs[6] = '{16'd40, 4, 128'hD2FE2800_01020304_A5A5A5A5_0F1E2D3C, 16'hFFFF, 1'b0};

        // Reset held two cycles with a pending request.
        resetB = 1'b1; start = 1'b0; expectedBytes = '0; mem_req_b = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack_b", 128'(mem_ack_b), 128'(1));
        check("rst_ceb", 128'(imem_ceb), 128'(1));
        check("rst_addr", 128'(imem_addr), 128'(0));
        check("rst_word", instruction_word, 128'(0));
        check("rst_mask", 128'(instruction_byte_valid), 128'(0));
        check("rst_done", 128'(done_reading_memory), 128'(0));
        mem_req_b = 1'b1;
        @(negedge clk);
        resetB = 1'b0;

        // Zero-length stream: done right after start, empty ack on request.
        do_start(16'd0);
        check("zero_done", 128'(done_reading_memory), 128'(1));
        req_word("zero_empty", 0, 0, '0, 16'h0000, 1'b1, 0);

        for (int v = 0; v < 7; v++) begin
            do_start(vecs[v].eb);
            req_word($sformatf("vec%0d", v), 0, vecs[v].n, vecs[v].word, vecs[v].mask, vecs[v].done, 0);
        end

        // 21-byte stream: full word, then 5-byte tail, then empty ack.
        do_start(16'd21);
        req_word("s21_w0", 0, 4, 128'hD2FE2800_01020304_A5A5A5A5_0F1E2D3C, 16'hFFFF, 1'b0, 0);
        req_word("s21_w1", 4, 2, 128'hCAFEBABE_DE000000_00000000_00000000, 16'hF800, 1'b1, 0);
        req_word("s21_empty", 0, 0, '0, 16'h0000, 1'b1, 0);

        // Request held low across the ack yields one ack only.
        do_start(16'd40);
        req_word("hold_w0", 0, 4, 128'hD2FE2800_01020304_A5A5A5A5_0F1E2D3C, 16'hFFFF, 1'b0, 6);
        req_word("hold_w1", 4, 4, 128'hCAFEBABE_DEADBEEF_13579BDF_2468ACE0, 16'hFFFF, 1'b0, 0);

        // Start during FETCH aborts the fetch without an ack.
        do_start(16'd40);
        @(negedge clk);
        mem_req_b = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; expectedBytes = 16'd8; mem_req_b = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch_quiet("abort_quiet", 8);
        req_word("abort_next", 0, 2, 128'hD2FE2800_01020304_00000000_00000000, 16'hFF00, 1'b1, 0);

        // Reset mid-fetch abandons the fetch and clears outputs.
        do_start(16'd16);
        @(negedge clk);
        mem_req_b = 1'b0;
        repeat (2) @(negedge clk);
        resetB = 1'b1; mem_req_b = 1'b1;
        @(negedge clk);
        resetB = 1'b0;
        check("midrst_mask", 128'(instruction_byte_valid), 128'(0));
        check("midrst_word", instruction_word, 128'(0));
        watch_quiet("midrst_quiet", 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
